// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between the requesting agents and rr_lock_arbiter.
// Handshake: req_i is a level held by each requester for as long as it wants the resource;
// there is no separate ready, and gnt_o (one-hot, registered) is the acknowledgement.
interface rr_lock_arbiter_if #(
  parameter int NO_OF_PORTS = 4
);
  localparam int IW = (NO_OF_PORTS > 1) ? $clog2(NO_OF_PORTS) : 1;

  logic [NO_OF_PORTS-1:0] req_i;
  logic [NO_OF_PORTS-1:0] gnt_o;
  logic                   gnt_valid_o;
  logic [IW-1:0]          gnt_id_o;

  modport master (
    output req_i,
    input  gnt_o,
    input  gnt_valid_o,
    input  gnt_id_o
  );

  modport slave (
    input  req_i,
    output gnt_o,
    output gnt_valid_o,
    output gnt_id_o
  );
endinterface

// File: rtl/rr_lock_arbiter.sv
// Registered round-robin arbiter with a bounded grant tenure (MAX_HOLD cycles while others wait).
// All grant outputs come straight from flops; dbg_state exposes the FSM (0 = IDLE, 1 = GRANT).
module rr_lock_arbiter #(
  parameter int NO_OF_PORTS = 4,
  parameter int MAX_HOLD    = 4
) (
  input  logic              clk,
  input  logic              reset,
  rr_lock_arbiter_if.slave  bus,
  output logic              dbg_state
);
  localparam int IW = (NO_OF_PORTS > 1) ? $clog2(NO_OF_PORTS) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX = IW'(NO_OF_PORTS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state;
  logic [IW-1:0]          ptr;
  logic [CW-1:0]          cnt;

  logic [NO_OF_PORTS-1:0] cand;
  logic                   owner_req;
  logic                   win_found;
  logic [IW-1:0]          win_idx;
  logic                   take;
  logic                   release_gnt;
  int                     j;

  // The current owner never competes against itself; in IDLE gnt_o is zero so cand == req_i.
  always_comb begin
    cand      = bus.req_i & ~bus.gnt_o;
    owner_req = |(bus.req_i & bus.gnt_o);
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = 0; i < NO_OF_PORTS; i++) begin
      j = (int'(ptr) + i) % NO_OF_PORTS;
      if (!win_found && cand[IW'(j)]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  // A new winner is taken from idle, after the owner drops, or once the owner's tenure is spent.
  always_comb begin
    take        = win_found && ((state == IDLE) || !owner_req || (cnt == CNT_MAX));
    release_gnt = (state == GRANT) && !owner_req && !win_found;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      ptr             <= '0;
      cnt             <= '0;
      bus.gnt_o       <= '0;
      bus.gnt_valid_o <= 1'b0;
      bus.gnt_id_o    <= '0;
    end else if (take) begin
      state           <= GRANT;
      ptr             <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      cnt             <= CW'(1);
      bus.gnt_o       <= NO_OF_PORTS'(1) << win_idx;
      bus.gnt_valid_o <= 1'b1;
      bus.gnt_id_o    <= win_idx;
    end else if (release_gnt) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.gnt_o       <= '0;
      bus.gnt_valid_o <= 1'b0;
      bus.gnt_id_o    <= '0;
    end else if ((state == GRANT) && (cnt < CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign dbg_state = state;
endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Registered round-robin arbiter with grant locking for NO_OF_PORTS requesters sharing one resource.
- Successor to the combinational fixed-priority arbiter: adds fairness, tenure limits and registered, glitch-free grant outputs.
- Sits between the requesting agents and the shared datapath. gnt_o drives the resource mux select, and gnt_id_o gives the binary index.

Parameters:
NO_OF_PORTS, 4, number of requesters (>=2)
MAX_HOLD, 4, maximum consecutive cycles one grant may be held while others wait (>=1)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  synchronous, active-low reset
req_i  input  NO_OF_PORTS  request per port, level, held high for as long as the port wants the resource
gnt_o  output  NO_OF_PORTS  registered one-hot grant; all zeros when idle
gnt_valid_o  output  1  high when any grant is active (equals |gnt_o)
gnt_id_o  output  $clog2(NO_OF_PORTS)  binary index of the granted port; 0 when not valid

Behaviour:
- Reset: reset sampled low at a clk edge forces the following on that edge, regardless of req_i:
  - gnt_o=0, gnt_valid_o=0, gnt_id_o=0
  - state=IDLE, rr pointer ptr=0, hold counter cnt=0
- Registered outputs. req_i is sampled at edge t, and the grant appears after edge t, so latency is 1 cycle. There is no combinational path from req_i to the outputs.
- Round-robin search: starting from index ptr, the first set bit of the candidate vector (wrapping modulo NO_OF_PORTS) wins.
  - On every new grant to port k: ptr <= (k+1) mod NO_OF_PORTS, cnt <= 1.
- State IDLE:
  - req_i==0: stay in IDLE, outputs zero.
  - Otherwise: grant the search winner over req_i and go to GRANT.
- State GRANT (port g granted):
  - req_i[g]==1 and cnt<MAX_HOLD: keep g, cnt <= cnt+1.
  - req_i[g]==1, cnt==MAX_HOLD, and another port requesting: pre-empt. Grant the search winner over req_i with bit g masked. No idle gap.
  - req_i[g]==1, cnt==MAX_HOLD, and no other port requesting: keep g, cnt saturates at MAX_HOLD.
  - req_i[g]==0 and other requests pending: hand off to the search winner on the next edge. No idle gap.
  - req_i[g]==0 and no requests: clear gnt_o, return to IDLE. ptr is unchanged.
- Invariants, checked every cycle:
  - gnt_o is one-hot or zero.
  - gnt_o[k]==1 implies req_i[k] was 1 at the preceding edge.
  - gnt_id_o matches gnt_o.
  - Any continuously asserted request is granted within (NO_OF_PORTS-1)*MAX_HOLD+1 cycles.
- Simultaneous events: a new request arriving on the same edge the granted port drops competes normally in the search from ptr.
- Reset mid-grant: the grant is revoked at that edge. The resource owner sees gnt_o fall with no handshake; requesters must re-arbitrate after reset.

Test Plan:
- Reset priority: reset low 2 cycles with req_i=4'b1111 -> gnt_o=0 and gnt_valid_o=0 throughout. First edge after release gives gnt_o=4'b0001, gnt_id_o=0.
- Full contention: req_i=4'b1111 held 20 cycles (MAX_HOLD=4) -> gnt_o is 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again. gnt_valid_o is never low.
- Lone requester: req_i=4'b0100 held 10 cycles, then 0 -> gnt_o=0100 for all 10 cycles, no pre-emption. gnt_o=0 one cycle after the drop; state IDLE.
- Early handoff: port 0 granted (cnt=2), req_i changes 0001->1010 -> next edge gnt_o=0010 (ptr was 1), gnt_id_o=1, no zero cycle. Then port 1 holds 4 cycles before 1000 is granted.
- Reset mid-operation: while gnt_o=0100, assert reset 1 cycle with req_i=0101 -> gnt_o=0 at that edge. After release the grant is 0001 (ptr reset to 0), not 0100.
- Random soak: 20 random req_i vectors via $urandom_range(0,15), each held 20 ns -> all invariants hold every cycle. Every held request is served within 13 cycles.
